video_source_mux: RTL and testbench

- Parametrised N-input pixel source selector feeding the LCD write-FIFO packer (oWr1/oWr2 format).
- Selects one of NUM_SRC RGB pixel streams by a one-hot select, registers it, and packs it with a delayed gray sideband into the two 16-bit write words.
- Select changes are accepted only inside vertical blanking, after a programmable settle count. Invalid selects are rejected and flagged.

---
 rtl/video_mux_pkg.sv | 23 ++
 rtl/vsel_sync.sv | 86 ++++++++
 rtl/video_source_mux.sv | 120 ++++++++++++
 tb/tb_video_source_mux.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_mux_pkg.sv
// rtl/video_mux_pkg.sv - shared types, pack widths, fill defaults and one-hot check for the video source mux
package video_mux_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_BLANK  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_HOLD   = 2'd3
  } vmux_state_t;

  localparam int COMP_W = 8;
  localparam int G_HI_W = 5;
  localparam int G_LO_W = 3;

  localparam logic [11:0] FILL_R_DEF = 12'hFF0;
  localparam logic [11:0] FILL_G_DEF = 12'hFF0;
  localparam logic [11:0] FILL_B_DEF = 12'h000;

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/vsel_sync.sv
// rtl/vsel_sync.sv - blanking-qualified select latch: FSM, blank counter, select register and error flag
module vsel_sync
  import video_mux_pkg::*;
#(
  parameter int NUM_SRC    = 8,
  parameter int BLANK_WAIT = 50
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               fval_i,
  input  logic [NUM_SRC-1:0] select_i,
  output logic [NUM_SRC-1:0] active_sel_o,
  output logic               switch_pulse_o,
  output logic               sel_error_o
);

  localparam int              CNT_W   = $clog2(BLANK_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLANK_WAIT);

  vmux_state_t        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_SRC-1:0] active_q;
  logic               err_q;
  logic               pulse_q;
  logic               sel_ok;

  assign sel_ok = is_onehot(16'(select_i));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_ACTIVE;
      cnt_q    <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_ACTIVE: begin
          cnt_q <= '0;
          if (!fval_i) state_q <= ST_BLANK;
        end
        ST_BLANK: begin
          if (fval_i) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
          end else begin
            // Counter stops at CNT_MAX, so it can never wrap.
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_MAX - 1'b1) state_q <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          if (sel_ok) begin
            active_q <= select_i;
            err_q    <= 1'b0;
            pulse_q  <= (select_i != active_q);
          end else begin
            err_q <= 1'b1;
          end
          if (fval_i) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (fval_i) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_ACTIVE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign active_sel_o   = active_q;
  assign switch_pulse_o = pulse_q;
  assign sel_error_o    = err_q;

endmodule

// File: rtl/video_source_mux.sv
// rtl/video_source_mux.sv - N-input pixel source selector and LCD write-word packer; VIDEO_MUX_MUTE_ON_SWITCH_EN mutes the first frame after a switch
module video_source_mux
  import video_mux_pkg::*;
#(
  parameter int               NUM_SRC    = 8,
  parameter int               PIX_W      = 12,
  parameter int               BLANK_WAIT = 50,
  parameter logic [PIX_W-1:0] FILL_R     = PIX_W'(FILL_R_DEF),
  parameter logic [PIX_W-1:0] FILL_G     = PIX_W'(FILL_G_DEF),
  parameter logic [PIX_W-1:0] FILL_B     = PIX_W'(FILL_B_DEF)
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iFval,
  input  logic [NUM_SRC-1:0]       iSelect,
  input  logic [NUM_SRC*PIX_W-1:0] iPix_R,
  input  logic [NUM_SRC*PIX_W-1:0] iPix_G,
  input  logic [NUM_SRC*PIX_W-1:0] iPix_B,
  input  logic [NUM_SRC-1:0]       iPix_Valid,
  input  logic [7:0]               iGray,
  output logic [15:0]              oWr1_data,
  output logic [15:0]              oWr2_data,
  output logic                     oWr_data_valid,
  output logic [NUM_SRC-1:0]       oActive_Sel,
  output logic                     oSel_Error
);

  logic [NUM_SRC-1:0] active_sel;
  logic               switch_pulse;
  logic               muted;
  logic               pix_unused;

  vsel_sync #(
    .NUM_SRC    (NUM_SRC),
    .BLANK_WAIT (BLANK_WAIT)
  ) u_vsel_sync (
    .clk_i          (iClk),
    .rst_ni         (iRst_n),
    .fval_i         (iFval),
    .select_i       (iSelect),
    .active_sel_o   (active_sel),
    .switch_pulse_o (switch_pulse),
    .sel_error_o    (oSel_Error)
  );

`ifdef VIDEO_MUX_MUTE_ON_SWITCH_EN
  logic mute_q;
  logic fval_q;

  // The pulse covers the first cycle after the switch, before mute_q catches up.
  assign muted = mute_q | switch_pulse;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      mute_q <= 1'b0;
      fval_q <= 1'b0;
    end else begin
      fval_q <= iFval;
      if (switch_pulse)          mute_q <= 1'b1;
      else if (fval_q && !iFval) mute_q <= 1'b0;
    end
  end

  assign pix_unused = ^{iPix_R, iPix_G, iPix_B};
`else
  assign muted      = 1'b0;
  assign pix_unused = ^{iPix_R, iPix_G, iPix_B, switch_pulse};
`endif

  logic [COMP_W-1:0] r8, g8, b8;
  logic              vld;
  logic [15:0]       wr1_d, wr1_q, wr2_d, wr2_q;
  logic              vld_q;

  always_comb begin
    r8  = FILL_R[PIX_W-1 -: COMP_W];
    g8  = FILL_G[PIX_W-1 -: COMP_W];
    b8  = FILL_B[PIX_W-1 -: COMP_W];
    vld = iPix_Valid[0];
    for (int k = 0; k < NUM_SRC; k++) begin
      if (active_sel[k]) begin
        vld = iPix_Valid[k];
        if (iPix_Valid[k]) begin
          r8 = iPix_R[k*PIX_W + (PIX_W-COMP_W) +: COMP_W];
          g8 = iPix_G[k*PIX_W + (PIX_W-COMP_W) +: COMP_W];
          b8 = iPix_B[k*PIX_W + (PIX_W-COMP_W) +: COMP_W];
        end else begin
          r8 = '0;
          g8 = '0;
          b8 = '0;
        end
      end
    end
    if (muted) begin
      r8 = '0;
      g8 = '0;
      b8 = '0;
    end
    wr1_d = {iGray[7], g8[COMP_W-1 -: G_HI_W], b8, iGray[6:5]};
    wr2_d = {iGray[4], g8[G_LO_W-1:0], iGray[3:2], r8, iGray[1:0]};
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wr1_q <= '0;
      wr2_q <= '0;
      vld_q <= 1'b0;
    end else begin
      wr1_q <= wr1_d;
      wr2_q <= wr2_d;
      vld_q <= vld;
    end
  end

  assign oWr1_data      = wr1_q;
  assign oWr2_data      = wr2_q;
  assign oWr_data_valid = vld_q;
  assign oActive_Sel    = active_sel;

endmodule

// File: tb/tb_video_source_mux.sv
// tb/tb_video_source_mux.sv - self-checking bench for video_source_mux (frame-level reference model, VIDEO_MUX_MUTE_ON_SWITCH_EN aware)
module tb_video_source_mux;

  localparam int NUM_SRC    = 8;
  localparam int PIX_W      = 12;
  localparam int BLANK_WAIT = 50;

  logic                     iClk = 1'b0;
  logic                     iRst_n;
  logic                     iFval;
  logic [NUM_SRC-1:0]       iSelect;
  logic [NUM_SRC*PIX_W-1:0] iPix_R, iPix_G, iPix_B;
  logic [NUM_SRC-1:0]       iPix_Valid;
  logic [7:0]               iGray;
  logic [15:0]              oWr1_data, oWr2_data;
  logic                     oWr_data_valid;
  logic [NUM_SRC-1:0]       oActive_Sel;
  logic                     oSel_Error;

  always #5 iClk = ~iClk;

  video_source_mux #(
    .NUM_SRC    (NUM_SRC),
    .PIX_W      (PIX_W),
    .BLANK_WAIT (BLANK_WAIT)
  ) dut (
    .iClk           (iClk),
    .iRst_n         (iRst_n),
    .iFval          (iFval),
    .iSelect        (iSelect),
    .iPix_R         (iPix_R),
    .iPix_G         (iPix_G),
    .iPix_B         (iPix_B),
    .iPix_Valid     (iPix_Valid),
    .iGray          (iGray),
    .oWr1_data      (oWr1_data),
    .oWr2_data      (oWr2_data),
    .oWr_data_valid (oWr_data_valid),
    .oActive_Sel    (oActive_Sel),
    .oSel_Error     (oSel_Error)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: frame-level view (length of the current low run of iFval).
  logic [NUM_SRC-1:0] m_sel;
  logic               m_err;
  logic               m_mute;
  logic               m_fval_prev;
  int                 low_run;

  typedef struct {
    logic [7:0]  gray;
    logic        v0;
    logic [15:0] wr1;
    logic [15:0] wr2;
    logic        vld;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input string name);
    logic [15:0] e1, e2;
    logic        ev;
    logic [7:0]  r, g, b;
    int          k;
    if (!iRst_n) begin
      e1 = '0; e2 = '0; ev = 1'b0;
    end else begin
      k = -1;
      for (int i = 0; i < NUM_SRC; i++) if (m_sel[i]) k = i;
      if (k < 0) begin
        r = 8'hFF; g = 8'hFF; b = 8'h00; ev = iPix_Valid[0];
      end else if (iPix_Valid[k]) begin
        r = 8'(iPix_R >> (k*PIX_W + PIX_W - 8));
        g = 8'(iPix_G >> (k*PIX_W + PIX_W - 8));
        b = 8'(iPix_B >> (k*PIX_W + PIX_W - 8));
        ev = 1'b1;
      end else begin
        r = 8'h00; g = 8'h00; b = 8'h00; ev = 1'b0;
      end
      if (m_mute) begin r = 8'h00; g = 8'h00; b = 8'h00; end
      e1 = {iGray[7], g[7:3], b, iGray[6:5]};
      e2 = {iGray[4], g[2:0], iGray[3:2], r, iGray[1:0]};
    end
    if (!iRst_n) begin
      m_sel = '0; m_err = 1'b0; m_mute = 1'b0; m_fval_prev = 1'b0; low_run = 0;
    end else begin
      if (m_fval_prev && !iFval) m_mute = 1'b0;
      if (low_run == BLANK_WAIT + 1) begin
        if ($countones(iSelect) == 1) begin
`ifdef VIDEO_MUX_MUTE_ON_SWITCH_EN
          if (iSelect != m_sel) m_mute = 1'b1;
`endif
          m_sel = iSelect;
          m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      low_run     = iFval ? 0 : low_run + 1;
      m_fval_prev = iFval;
    end
    @(posedge iClk);
    #1;
    check({name, ".wr1"}, oWr1_data, e1);
    check({name, ".wr2"}, oWr2_data, e2);
    check({name, ".vld"}, oWr_data_valid, ev);
    check({name, ".sel"}, oActive_Sel, m_sel);
    check({name, ".err"}, oSel_Error, m_err);
  endtask

  task automatic randomize_pixels();
    for (int s = 0; s < NUM_SRC; s++) begin
      iPix_R[s*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 4095));
      iPix_G[s*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 4095));
      iPix_B[s*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 4095));
    end
    iPix_Valid = NUM_SRC'($urandom);
    iGray      = 8'($urandom);
  endtask

  task automatic blank_frame(input int n_low, input logic [NUM_SRC-1:0] sel, input string name);
    iSelect = sel;
    iFval   = 1'b0;
    repeat (n_low) tick(name);
    iFval = 1'b1;
    repeat (5) tick(name);
  endtask

  initial begin
    vecs[0] = '{gray: 8'hA5, v0: 1'b1, wr1: 16'hFC01, wr2: 16'h77FD, vld: 1'b1};
    vecs[1] = '{gray: 8'hA5, v0: 1'b0, wr1: 16'hFC01, wr2: 16'h77FD, vld: 1'b0};
    vecs[2] = '{gray: 8'h00, v0: 1'b1, wr1: 16'h7C00, wr2: 16'h73FC, vld: 1'b1};
    vecs[3] = '{gray: 8'hFF, v0: 1'b0, wr1: 16'hFC03, wr2: 16'hFFFF, vld: 1'b0};

    iRst_n = 1'b0; iFval = 1'b1; iSelect = '0; iPix_Valid = '0;
    iPix_R = '0; iPix_G = '0; iPix_B = '0; iGray = 8'h00;
    tick("reset");
    tick("reset");
    check("reset_wr1", oWr1_data, 16'h0000);
    check("reset_sel", oActive_Sel, '0);
    iRst_n = 1'b1;

    // Fill colour before any switch; gray sideband delayed one cycle.
    for (int i = 0; i < 4; i++) begin
      iGray = vecs[i].gray;
      iPix_Valid[0] = vecs[i].v0;
      tick("fill");
      check("fill_wr1", oWr1_data, vecs[i].wr1);
      check("fill_wr2", oWr2_data, vecs[i].wr2);
      check("fill_vld", oWr_data_valid, vecs[i].vld);
    end

    // Long blanking: select 2 applied exactly 51 cycles after the fall.
    iPix_Valid = 8'h04;
    iPix_R[2*PIX_W +: PIX_W] = 12'hAB0;
    iSelect = 8'h04;
    iFval   = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick("switch");
      if (c == 50) check("switch_sel_c50", oActive_Sel, 8'h00);
      if (c == 51) check("switch_sel_c51", oActive_Sel, 8'h04);
      if (c == 52) check("switch_r_c52", oWr2_data[9:2], 8'hAB);
    end
    iFval = 1'b1;
    repeat (10) tick("switch_act");

    // Short blanking intervals never switch.
    for (int f = 0; f < 3; f++) begin
      blank_frame(30, 8'h10, "short");
      check("short_sel", oActive_Sel, 8'h04);
    end
    blank_frame(50, 8'h10, "edge50");
    check("edge50_sel", oActive_Sel, 8'h04);

    // iFval rising on the sampling cycle still samples.
    iSelect = 8'h10;
    iFval   = 1'b0;
    repeat (51) tick("edge51");
    iFval = 1'b1;
    tick("edge51");
    check("edge51_sel", oActive_Sel, 8'h10);
    repeat (5) tick("edge51");

    // Invalid request rejected and flagged, then cleared by a good one.
    blank_frame(60, 8'h06, "bad_sel");
    check("bad_sel_keep", oActive_Sel, 8'h10);
    check("bad_sel_err", oSel_Error, 1'b1);
    blank_frame(60, 8'h00, "zero_sel");
    check("zero_sel_err", oSel_Error, 1'b1);
    blank_frame(60, 8'h01, "good_sel");
    check("good_sel_err", oSel_Error, 1'b0);
    check("good_sel_sel", oActive_Sel, 8'h01);

    // Valid of the selected source gates the components.
    blank_frame(60, 8'h02, "vsel2");
    iPix_R[1*PIX_W +: PIX_W] = 12'h5A0;
    iPix_G[1*PIX_W +: PIX_W] = 12'hC30;
    iPix_B[1*PIX_W +: PIX_W] = 12'h3C0;
    repeat (12) tick("vsel2_frame");
    for (int i = 0; i < 3; i++) begin
      iPix_Valid[1] = (i != 1);
      tick("vtoggle");
      check("vtoggle_vld", oWr_data_valid, (i != 1));
      if (i == 1) begin
        check("vtoggle_zero1", oWr1_data & 16'h7FFC, 16'h0000);
        check("vtoggle_zero2", oWr2_data & 16'h73FC, 16'h0000);
      end
    end

    // Reset in the middle of a blank count restarts everything.
    iSelect = 8'h08;
    iFval   = 1'b0;
    repeat (30) tick("mid_rst");
    iRst_n = 1'b0;
    tick("mid_rst");
    check("mid_rst_sel", oActive_Sel, 8'h00);
    iRst_n = 1'b1;
    repeat (25) tick("mid_rst");
    iFval = 1'b1;
    repeat (3) tick("mid_rst");
    check("mid_rst_nosw", oActive_Sel, 8'h00);

    // Randomized frames against the reference model.
    for (int f = 0; f < 24; f++) begin
      iFval = 1'b1;
      repeat ($urandom_range(20, 60)) begin
        randomize_pixels();
        tick("rand_act");
      end
      if ($urandom_range(0, 9) < 7) iSelect = NUM_SRC'(1 << $urandom_range(0, NUM_SRC - 1));
      else                          iSelect = NUM_SRC'($urandom);
      iFval = 1'b0;
      repeat ($urandom_range(40, 60)) begin
        randomize_pixels();
        tick("rand_blank");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
